// File: rtl/sc_pkg.sv
// Shared definitions for the split-unipolar stochastic front end: FSM states,
// maximal-length LFSR tap masks and counter sizing.
package sc_pkg;

   typedef enum logic [2:0] {
      IDLE,
      CLR,
      STREAM,
      ACT,
      DONE
   } sc_state_e;

   // Fibonacci tap masks; bit i-1 set means stage i feeds the XOR.
   function automatic logic [15:0] lfsr_taps(input int w);
      logic [15:0] taps;
      case (w)
         3:       taps = 16'b0000_0000_0000_0110;
         4:       taps = 16'b0000_0000_0000_1100;
         5:       taps = 16'b0000_0000_0001_0100;
         6:       taps = 16'b0000_0000_0011_0000;
         7:       taps = 16'b0000_0000_0110_0000;
         8:       taps = 16'b0000_0000_1011_1000;
         9:       taps = 16'b0000_0001_0001_0000;
         10:      taps = 16'b0000_0010_0100_0000;
         11:      taps = 16'b0000_0101_0000_0000;
         12:      taps = 16'b0000_1000_0010_1001;
         13:      taps = 16'b0001_0000_0000_1101;
         14:      taps = 16'b0010_0000_0001_0101;
         15:      taps = 16'b0110_0000_0000_0000;
         16:      taps = 16'b1101_0000_0000_1000;
         default: taps = 16'b0000_0000_0000_0000;
      endcase
      return taps;
   endfunction

   // Bits needed to hold a count of 0..n-1.
   function automatic int cnt_width(input int n);
      return (n <= 2) ? 1 : $clog2(n);
   endfunction

endpackage

// File: rtl/sc_lfsr.sv
// W-bit maximal-length Fibonacci LFSR with synchronous seed reload; a nonzero
// seed keeps it cycling through 1..2^W-1 without ever reaching zero.
module sc_lfsr
   import sc_pkg::*;
#(
   parameter int W = 7,
   parameter logic [W-1:0] SEED = 1
) (
   input  logic         clk,
   input  logic         reset,
   input  logic         load,
   input  logic         adv,
   output logic [W-1:0] q
);

   localparam logic [15:0]  TAPS_ALL = lfsr_taps(W);
   localparam logic [W-1:0] TAPS     = TAPS_ALL[W-1:0];

   logic [W-1:0] q_q;
   logic [W-1:0] q_d;

   // NOTE: every always_comb output gets a default first so no path can infer a latch.
   always_comb begin
      q_d = q_q;
      if (load) begin
         q_d = SEED;
      end else if (adv) begin
         q_d = {q_q[W-2:0], ^(q_q & TAPS)};
      end
   end

   // NOTE: state flops use non-blocking assignments so all of them update together at the edge.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         q_q <= SEED;
      end else begin
         q_q <= q_d;
      end
   end

   assign q = q_q;

endmodule

// File: rtl/bin2sc_split.sv
// Binary-to-stochastic converter: takes one signed operand and emits STREAM_LEN
// cycles of 2-lane split-unipolar bits, sequencing the downstream sc2bin_v2.
module bin2sc_split
   import sc_pkg::*;
#(
   parameter int BITWIDTH_IN = 8,
   parameter int STREAM_LEN  = 127,
   parameter int ACT_CYCLES  = 1,
   parameter int SEED0       = 1,
   parameter int SEED1       = 'h55
) (
   input  logic                   clk,
   input  logic                   reset,
   input  logic                   in_valid,
   input  logic [BITWIDTH_IN-1:0] in_data,
   output logic                   in_ready,
   output logic [1:0]             sc_pos,
   output logic [1:0]             sc_neg,
   output logic                   clr,
   output logic                   cnt_en,
   output logic                   act_en,
   output logic                   busy,
   output logic                   done
);

   localparam int W  = BITWIDTH_IN - 1;
   localparam int CW = cnt_width(STREAM_LEN);
   localparam int AW = cnt_width((ACT_CYCLES > 0) ? ACT_CYCLES : 1);

   localparam logic [CW-1:0] CNT_LAST = CW'(STREAM_LEN - 1);
   localparam logic [AW-1:0] ACT_LAST = AW'((ACT_CYCLES > 0) ? ACT_CYCLES - 1 : 0);
   localparam logic [31:0]   SEED0_V  = SEED0;
   localparam logic [31:0]   SEED1_V  = SEED1;

   sc_state_e     state_q, state_d;
   logic [CW-1:0] cnt_q, cnt_d;
   logic [AW-1:0] act_cnt_q, act_cnt_d;
   logic [W-1:0]  mag_q, mag_d;
   logic          sign_q, sign_d;

   logic [BITWIDTH_IN-1:0] neg_data;
   logic [W-1:0]           lfsr0, lfsr1;
   logic [1:0]             lanes;

   assign neg_data = ~in_data + BITWIDTH_IN'(1);

   always_comb begin
      state_d   = state_q;
      cnt_d     = cnt_q;
      act_cnt_d = act_cnt_q;
      mag_d     = mag_q;
      sign_d    = sign_q;
      case (state_q)
         IDLE: begin
            if (in_valid) begin
               sign_d  = in_data[BITWIDTH_IN-1];
               state_d = CLR;
               // The most negative code negates onto itself; saturate it to full scale.
               if (!in_data[BITWIDTH_IN-1]) begin
                  mag_d = in_data[W-1:0];
               end else if (neg_data[W]) begin
                  mag_d = '1;
               end else begin
                  mag_d = neg_data[W-1:0];
               end
            end
         end
         CLR: begin
            cnt_d   = '0;
            state_d = STREAM;
         end
         STREAM: begin
            if (cnt_q == CNT_LAST) begin
               act_cnt_d = '0;
               state_d   = (ACT_CYCLES == 0) ? DONE : ACT;
            end else begin
               cnt_d = cnt_q + CW'(1);
            end
         end
         ACT: begin
            if (act_cnt_q == ACT_LAST) begin
               state_d = DONE;
            end else begin
               act_cnt_d = act_cnt_q + AW'(1);
            end
         end
         DONE:    state_d = IDLE;
         default: state_d = IDLE;
      endcase
   end

   // NOTE: only control/datapath registers are reset; there is no memory array here to clear.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state_q   <= IDLE;
         cnt_q     <= '0;
         act_cnt_q <= '0;
         mag_q     <= '0;
         sign_q    <= 1'b0;
      end else begin
         state_q   <= state_d;
         cnt_q     <= cnt_d;
         act_cnt_q <= act_cnt_d;
         mag_q     <= mag_d;
         sign_q    <= sign_d;
      end
   end

   sc_lfsr #(.W(W), .SEED(SEED0_V[W-1:0])) u_lfsr0 (
      .clk   (clk),
      .reset (reset),
      .load  (state_q == CLR),
      .adv   (state_q == STREAM),
      .q     (lfsr0)
   );

   sc_lfsr #(.W(W), .SEED(SEED1_V[W-1:0])) u_lfsr1 (
      .clk   (clk),
      .reset (reset),
      .load  (state_q == CLR),
      .adv   (state_q == STREAM),
      .q     (lfsr1)
   );

   // Outputs decode registered state only, so nothing flows combinationally from the inputs.
   assign in_ready = (state_q == IDLE);
   assign busy     = (state_q != IDLE);
   assign clr      = (state_q == CLR);
   assign cnt_en   = (state_q == STREAM);
   assign act_en   = (state_q == ACT);
   assign done     = (state_q == DONE);

   assign lanes  = {(lfsr1 <= mag_q), (lfsr0 <= mag_q)};
   assign sc_pos = (cnt_en && !sign_q) ? lanes : 2'b00;
   assign sc_neg = (cnt_en &&  sign_q) ? lanes : 2'b00;

endmodule

// File: tb/tb_bin2sc_split.sv
// Directed bench for bin2sc_split: per-conversion lane popcounts, control
// sequencing, busy-time input rejection and mid-stream reset.
module tb_bin2sc_split;

   logic       clk = 1'b0;
   logic       reset;
   logic       in_valid;
   logic [7:0] in_data;
   logic       in_ready;
   logic [1:0] sc_pos;
   logic [1:0] sc_neg;
   logic       clr;
   logic       cnt_en;
   logic       act_en;
   logic       busy;
   logic       done;

   int tests = 0;
   int fails = 0;

   int r_stream, r_pos0, r_pos1, r_neg0, r_neg1, r_pos_all, r_neg_all;
   int r_done_n, r_done_cnt, r_ready_bad, r_leak, r_clr_n, r_clr_cnt, r_act_n, r_act_cnt;
   int r_ready_after;

   bin2sc_split #(
      .BITWIDTH_IN (8),
      .STREAM_LEN  (127),
      .ACT_CYCLES  (1),
      .SEED0       (1),
      .SEED1       ('h55)
   ) dut (
      .clk      (clk),
      .reset    (reset),
      .in_valid (in_valid),
      .in_data  (in_data),
      .in_ready (in_ready),
      .sc_pos   (sc_pos),
      .sc_neg   (sc_neg),
      .clr      (clr),
      .cnt_en   (cnt_en),
      .act_en   (act_en),
      .busy     (busy),
      .done     (done)
   );

   always #5 clk = ~clk;

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      tests++;
      assert (obs === exp) else begin
         fails++;
         $error("FAIL %s observed=%0d expected=%0d", tag, $signed(obs), $signed(exp));
      end
   endtask

   task automatic check_idle_outputs(input string pfx);
      chk({pfx, "_in_ready"}, 32'(in_ready), 1);
      chk({pfx, "_busy"},     32'(busy),     0);
      chk({pfx, "_sc_pos"},   32'(sc_pos),   0);
      chk({pfx, "_sc_neg"},   32'(sc_neg),   0);
      chk({pfx, "_ctrl"},     32'({clr, cnt_en, act_en, done}), 0);
   endtask

   // Offers v at a negedge, then records cycle-by-cycle activity. Cycle n=1 is
   // the cycle after the accepting edge. abort_at>0 asserts reset in that cycle.
   task automatic convert(input logic [7:0] v, input bit hold, input int abort_at);
      r_stream = 0; r_pos0 = 0; r_pos1 = 0; r_neg0 = 0; r_neg1 = 0;
      r_pos_all = 0; r_neg_all = 0; r_done_n = 0; r_done_cnt = 0; r_ready_bad = 0;
      r_leak = 0; r_clr_n = 0; r_clr_cnt = 0; r_act_n = 0; r_act_cnt = 0; r_ready_after = 0;
      in_valid = 1'b1;
      in_data  = v;
      @(posedge clk);
      #1;
      if (hold) begin
         in_data = v ^ 8'hA5;
      end else begin
         in_valid = 1'b0;
         in_data  = ~v;
      end
      for (int n = 1; n <= 300; n++) begin
         @(negedge clk);
         if (hold && n == 60) in_data = 8'h81;
         if (n == abort_at) begin
            #2 reset = 1'b1;
            #1;
            check_idle_outputs("abort");
            chk("abort_stream_so_far", r_stream, 39);
            in_valid = 1'b0;
            return;
         end
         if (cnt_en) begin
            r_stream++;
            r_pos0 += int'(sc_pos[0]);
            r_pos1 += int'(sc_pos[1]);
            r_neg0 += int'(sc_neg[0]);
            r_neg1 += int'(sc_neg[1]);
            if (sc_pos == 2'b11) r_pos_all++;
            if (sc_neg == 2'b11) r_neg_all++;
         end else if (sc_pos != 2'b00 || sc_neg != 2'b00) begin
            r_leak++;
         end
         if (clr)    begin r_clr_n = n; r_clr_cnt++; end
         if (act_en) begin r_act_n = n; r_act_cnt++; end
         if (done)   begin r_done_n = n; r_done_cnt++; end
         if (r_done_cnt == 0 && in_ready) r_ready_bad++;
         if (r_done_cnt != 0 && n == r_done_n + 1) begin
            r_ready_after = int'(in_ready);
            in_valid = 1'b0;
            break;
         end
      end
      in_valid = 1'b0;
   endtask

   task automatic check_run(input string pfx, input int p0, input int p1, input int n0, input int n1);
      chk({pfx, "_stream_cycles"}, r_stream, 127);
      chk({pfx, "_pos_lane0"},     r_pos0, p0);
      chk({pfx, "_pos_lane1"},     r_pos1, p1);
      chk({pfx, "_neg_lane0"},     r_neg0, n0);
      chk({pfx, "_neg_lane1"},     r_neg1, n1);
      chk({pfx, "_sc_outside"},    r_leak, 0);
      chk({pfx, "_clr_cycle"},     r_clr_n, 1);
      chk({pfx, "_clr_count"},     r_clr_cnt, 1);
      chk({pfx, "_act_cycle"},     r_act_n, 129);
      chk({pfx, "_act_count"},     r_act_cnt, 1);
      chk({pfx, "_done_cycle"},    r_done_n, 130);
      chk({pfx, "_done_count"},    r_done_cnt, 1);
      chk({pfx, "_ready_busy"},    r_ready_bad, 0);
      chk({pfx, "_ready_after"},   r_ready_after, 1);
   endtask

   initial begin
      int acc;
      reset    = 1'b1;
      in_valid = 1'b0;
      in_data  = 8'h00;
      repeat (2) @(negedge clk);
      check_idle_outputs("reset");
      reset = 1'b0;
      @(negedge clk);
      check_idle_outputs("post_reset");

      convert(8'd0, 1'b0, 0);
      check_run("zero", 0, 0, 0, 0);

      convert(8'd127, 1'b0, 0);
      check_run("p127", 127, 127, 0, 0);
      chk("p127_all_ones", r_pos_all, 127);
      chk("p127_count", r_pos0 + r_pos1 - r_neg0 - r_neg1, 254);

      convert(8'd64, 1'b0, 0);
      check_run("p64", 64, 64, 0, 0);

      convert(8'hC0, 1'b0, 0);
      check_run("n64", 0, 0, 64, 64);
      acc = r_pos0 + r_pos1 - r_neg0 - r_neg1;
      chk("n64_count", acc, -128);
      chk("n64_relu", (acc < 0) ? 0 : acc, 0);

      convert(8'h80, 1'b0, 0);
      check_run("n128", 0, 0, 127, 127);
      chk("n128_all_ones", r_neg_all, 127);

      // in_valid stays high with changing data; only the first value counts.
      convert(8'd64, 1'b1, 0);
      check_run("hold", 64, 64, 0, 0);
      @(negedge clk);
      chk("hold_no_reaccept", 32'(in_ready), 1);

      convert(8'd100, 1'b0, 41);
      @(negedge clk);
      reset = 1'b0;
      repeat (3) begin
         @(negedge clk);
         chk("after_abort_done", 32'(done), 0);
         chk("after_abort_ready", 32'(in_ready), 1);
      end

      convert(8'd10, 1'b0, 0);
      check_run("p10", 10, 10, 0, 0);
      chk("p10_count", r_pos0 + r_pos1, 20);

      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end

endmodule
